// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op/state encodings and sizing for the multiply/divide unit.
package mdu_pkg;
   localparam int MDU_WIDTH = 32;
   localparam int MDU_ITER  = MDU_WIDTH;
   typedef enum logic [1:0] {MDU_MULT = 2'b00, MDU_MULTU = 2'b01, MDU_DIV = 2'b10, MDU_DIVU = 2'b11} mdu_op_e;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
endpackage

// File: rtl/mdu_if.sv
// mdu_if: ALU-side request/response bundle for the multiply/divide unit.
interface mdu_if #(parameter int WIDTH = mdu_pkg::MDU_WIDTH);
   import mdu_pkg::*;
   logic             validIn;
   mdu_op_e          op;
   logic [WIDTH-1:0] SrcA;
   logic [WIDTH-1:0] SrcB;
   logic             mthi_en;
   logic             mtlo_en;
   logic             validOut;
   logic             busy;
   logic             div_by_zero;
   logic [WIDTH-1:0] Hi;
   logic [WIDTH-1:0] Lo;
   modport master (output validIn, op, SrcA, SrcB, mthi_en, mtlo_en,
                   input validOut, busy, div_by_zero, Hi, Lo);
   modport slave  (input validIn, op, SrcA, SrcB, mthi_en, mtlo_en,
                   output validOut, busy, div_by_zero, Hi, Lo);
endinterface

// File: rtl/mdu_abs_sign.sv
// mdu_abs_sign: two's-complement negation when neg_en is set, or when abs_en is set
// and the input is negative (absolute value; the most negative value maps to itself).
module mdu_abs_sign #(parameter int W = 32) (
   input  logic [W-1:0] a,
   input  logic         abs_en,
   input  logic         neg_en,
   output logic [W-1:0] y
);
   assign y = ((abs_en & a[W-1]) | neg_en) ? -a : a;
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU engine that owns the Hi/Lo registers.
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH = MDU_ITER
) (
   input  logic clk,
   input  logic reset,
   mdu_if.slave bus
);
   localparam int CW = $clog2(WIDTH);
   state_e             state_q, state_d;
   mdu_op_e            op_q, op_d;
   logic [2*WIDTH-1:0] p_q, p_d, step, prod_fix;
   logic [WIDTH-1:0]   b_q, b_d, hi_q, hi_d, lo_q, lo_d, abs_a, abs_b, quo_fix, rem_fix;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
   logic               valid_q, valid_d, busy_q, busy_d, dbz_q, dbz_d;
   logic               in_signed;
   logic [WIDTH:0]     sum, rs, diff;
   assign in_signed = !bus.op[0];
   mdu_abs_sign #(.W(WIDTH)) u_abs_a (.a(bus.SrcA), .abs_en(in_signed), .neg_en(1'b0), .y(abs_a));
   mdu_abs_sign #(.W(WIDTH)) u_abs_b (.a(bus.SrcB), .abs_en(in_signed), .neg_en(1'b0), .y(abs_b));
   // p_q is {acc, multiplier} for multiply and {remainder, dividend/quotient} for divide
   assign sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, b_q} : '0);
   assign rs   = p_q[2*WIDTH-1:WIDTH-1];
   assign diff = rs - {1'b0, b_q};
   assign step = op_q[1] ? {diff[WIDTH] ? rs[WIDTH-1:0] : diff[WIDTH-1:0], p_q[WIDTH-2:0], !diff[WIDTH]}
                         : {sum, p_q[WIDTH-1:1]};
   mdu_abs_sign #(.W(2*WIDTH)) u_fix_p (.a(step), .abs_en(1'b0), .neg_en(neg_res_q), .y(prod_fix));
   mdu_abs_sign #(.W(WIDTH)) u_fix_q (.a(step[WIDTH-1:0]), .abs_en(1'b0), .neg_en(neg_res_q), .y(quo_fix));
   mdu_abs_sign #(.W(WIDTH)) u_fix_r (.a(step[2*WIDTH-1:WIDTH]), .abs_en(1'b0), .neg_en(neg_rem_q), .y(rem_fix));
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      p_d       = p_q;
      b_d       = b_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      dbz_d     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.validIn) begin
               op_d      = bus.op;
               b_d       = abs_b;
               p_d       = {{WIDTH{1'b0}}, abs_a};
               cnt_d     = '0;
               neg_res_d = in_signed & (bus.SrcA[WIDTH-1] ^ bus.SrcB[WIDTH-1]);
               neg_rem_d = in_signed & bus.SrcA[WIDTH-1];
               if (bus.op[1] && bus.SrcB == '0) begin
                  state_d = DONE;
                  hi_d    = bus.SrcA;
                  lo_d    = '1;
                  dbz_d   = 1'b1;
               end else begin
                  state_d = BUSY;
               end
            end else begin
               hi_d = bus.mthi_en ? bus.SrcA : hi_q;
               lo_d = bus.mtlo_en ? bus.SrcB : lo_q;
            end
         end
         BUSY: begin
            p_d   = step;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = DONE;
               hi_d    = op_q[1] ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
               lo_d    = op_q[1] ? quo_fix : prod_fix[WIDTH-1:0];
            end
         end
         default: state_d = IDLE;
      endcase
      valid_d = state_d == DONE;
      busy_d  = state_d != IDLE;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         op_q      <= MDU_MULT;
         p_q       <= '0;
         b_q       <= '0;
         cnt_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         dbz_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         p_q       <= p_d;
         b_q       <= b_d;
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
         dbz_q     <= dbz_d;
      end
   end
   assign bus.validOut    = valid_q;
   assign bus.busy        = busy_q;
   assign bus.div_by_zero = dbz_q;
   assign bus.Hi          = hi_q;
   assign bus.Lo          = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed checks of mult_div_unit results, latency, move-to writes and reset abort.
module tb_mult_div_unit;
   import mdu_pkg::*;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int tests = 0;
   int fails = 0;
   mdu_if bus ();
   mult_div_unit dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_op(input string tag, input mdu_op_e o, input logic [31:0] a, input logic [31:0] b,
                        input int lat_exp, input logic [31:0] hi_exp, input logic [31:0] lo_exp,
                        input logic dbz_exp);
      int lat = 1;
      int idle = 0;
      bus.validIn = 1'b1;
      bus.op      = o;
      bus.SrcA    = a;
      bus.SrcB    = b;
      tick;
      while (!bus.validOut && lat < 40) begin
         if (!bus.busy) idle++;
         tick;
         lat++;
      end
      bus.validIn = 1'b0;
      chk({tag, " latency"}, lat, lat_exp);
      chk({tag, " busy_gap"}, idle, 0);
      chk({tag, " busy_done"}, bus.busy, 1);
      chk({tag, " Hi"}, bus.Hi, hi_exp);
      chk({tag, " Lo"}, bus.Lo, lo_exp);
      chk({tag, " dbz"}, bus.div_by_zero, dbz_exp);
      tick;
      chk({tag, " pulse_end"}, bus.validOut, 0);
      chk({tag, " idle"}, bus.busy, 0);
   endtask

   initial begin
      int lat;
      int vcount;
      bus.validIn = 1'b0;
      bus.op      = MDU_MULT;
      bus.SrcA    = '0;
      bus.SrcB    = '0;
      bus.mthi_en = 1'b0;
      bus.mtlo_en = 1'b0;
      tick;
      tick;
      chk("rst Hi", bus.Hi, 0);
      chk("rst Lo", bus.Lo, 0);
      chk("rst busy", bus.busy, 0);
      chk("rst validOut", bus.validOut, 0);
      chk("rst dbz", bus.div_by_zero, 0);
      reset = 1'b0;
      tick;

      bus.mthi_en = 1'b1;
      bus.SrcA    = 32'h1234_5678;
      tick;
      bus.mthi_en = 1'b0;
      chk("mthi Hi", bus.Hi, 32'h1234_5678);
      chk("mthi Lo", bus.Lo, 0);
      bus.mthi_en = 1'b1;
      bus.mtlo_en = 1'b1;
      bus.SrcA    = 32'hA5A5_A5A5;
      bus.SrcB    = 32'h5A5A_5A5A;
      tick;
      bus.mthi_en = 1'b0;
      bus.mtlo_en = 1'b0;
      chk("mt both Hi", bus.Hi, 32'hA5A5_A5A5);
      chk("mt both Lo", bus.Lo, 32'h5A5A_5A5A);

      do_op("MULT", MDU_MULT, 32'hFFFF_FFFE, 32'd3, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
      do_op("MULTU", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
      do_op("DIV -7/2", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
      do_op("DIVU 7/2", MDU_DIVU, 32'd7, 32'd2, 33, 32'd1, 32'd3, 1'b0);
      do_op("DIV min/-1", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000, 1'b0);
      do_op("DIV 5/0", MDU_DIV, 32'd5, 32'd0, 1, 32'd5, 32'hFFFF_FFFF, 1'b1);

      // operands and mtlo change while busy; neither may disturb Lo or the result
      bus.validIn = 1'b1;
      bus.op      = MDU_DIVU;
      bus.SrcA    = 32'd100;
      bus.SrcB    = 32'd7;
      tick;
      bus.mtlo_en = 1'b1;
      bus.SrcA    = 32'd0;
      bus.SrcB    = 32'hDEAD_BEEF;
      lat = 1;
      repeat (3) begin
         tick;
         lat++;
      end
      chk("busy mtlo Lo", bus.Lo, 32'hFFFF_FFFF);
      while (!bus.validOut && lat < 40) begin
         tick;
         lat++;
      end
      bus.validIn = 1'b0;
      bus.mtlo_en = 1'b0;
      chk("DIVU 100/7 latency", lat, 33);
      chk("DIVU 100/7 Lo", bus.Lo, 32'd14);
      chk("DIVU 100/7 Hi", bus.Hi, 32'd2);
      tick;

      bus.validIn = 1'b1;
      bus.op      = MDU_MULT;
      bus.SrcA    = 32'h0000_1234;
      bus.SrcB    = 32'h0000_5678;
      tick;
      repeat (9) tick;
      chk("pre-abort busy", bus.busy, 1);
      reset       = 1'b1;
      bus.validIn = 1'b0;
      tick;
      reset = 1'b0;
      chk("abort busy", bus.busy, 0);
      chk("abort Hi", bus.Hi, 0);
      chk("abort Lo", bus.Lo, 0);
      vcount = 0;
      repeat (40) begin
         if (bus.validOut) vcount++;
         tick;
      end
      chk("abort no validOut", vcount, 0);

      bus.validIn = 1'b1;
      bus.op      = MDU_MULTU;
      bus.SrcA    = 32'd3;
      bus.SrcB    = 32'd4;
      bus.mtlo_en = 1'b1;
      tick;
      bus.mtlo_en = 1'b0;
      chk("mtlo with validIn Lo", bus.Lo, 0);
      lat = 1;
      while (!bus.validOut && lat < 40) begin
         tick;
         lat++;
      end
      bus.validIn = 1'b0;
      chk("MULTU 3*4 latency", lat, 33);
      chk("MULTU 3*4 Lo", bus.Lo, 32'd12);
      chk("MULTU 3*4 Hi", bus.Hi, 32'd0);
      tick;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
